// File: rtl/stream_fifo_link_if.sv
// Valid/ready stream bundle for stream_fifo_link: upstream input side plus downstream output side.
interface stream_fifo_link_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  val_in;
    logic                  ready_upward;
    logic [DATA_WIDTH-1:0] din;
    logic                  val_out;
    logic                  ready_downward;
    logic [DATA_WIDTH-1:0] dout;

    // Environment side: drives upstream words and downstream ready.
    modport master (
        output val_in, din, ready_downward,
        input  ready_upward, val_out, dout
    );

    // Buffer side.
    modport slave (
        input  val_in, din, ready_downward,
        output ready_upward, val_out, dout
    );
endinterface

// File: rtl/stream_fifo_link.sv
// stream_fifo_link: elastic first-word-fall-through valid/ready buffer between two stream tiles.
// Optional macro STREAM_FIFO_OUTREG_EN adds a dedicated output register stage
// (2-cycle latency, DEPTH+1 capacity); default build reads dout straight from RAM.
module stream_fifo_link #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned CNT_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    stream_fifo_link_if.slave    bus,
    output logic [CNT_WIDTH-1:0] count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wptr_q, wptr_d;
    logic [AW-1:0]         rptr_q, rptr_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [CNT_WIDTH-1:0]  st_cnt;
    logic                  st_full;
    logic                  push;
    logic                  pop;
    logic                  ram_rd;

    // Upstream ready depends only on storage occupancy and reset, never on downstream ready.
    assign st_full          = (st_cnt == CNT_WIDTH'(DEPTH));
    assign bus.ready_upward = !st_full && !reset;
    assign push             = bus.val_in && bus.ready_upward;
    assign pop              = bus.val_out && bus.ready_downward;
    assign count            = count_q;

`ifdef STREAM_FIFO_OUTREG_EN
    logic                  out_vld_q, out_vld_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [CNT_WIDTH-1:0]  st_cnt_q, st_cnt_d;

    // Refill the output register from RAM whenever it is empty or being drained.
    assign ram_rd      = (st_cnt_q != CNT_WIDTH'(0)) && (!out_vld_q || pop);
    assign st_cnt      = st_cnt_q;
    assign bus.val_out = out_vld_q;
    assign bus.dout    = out_data_q;

    // Output stage and RAM-only occupancy next state.
    always_comb begin
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        st_cnt_d   = st_cnt_q;
        if (ram_rd) begin
            out_vld_d  = 1'b1;
            out_data_d = mem_q[rptr_q];
        end else if (pop) begin
            out_vld_d = 1'b0;
        end
        case ({push, ram_rd})
            2'b10:   st_cnt_d = st_cnt_q + CNT_WIDTH'(1);
            2'b01:   st_cnt_d = st_cnt_q - CNT_WIDTH'(1);
            default: st_cnt_d = st_cnt_q;
        endcase
    end

    // Output stage registers; reset empties the stage immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            st_cnt_q   <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            st_cnt_q   <= st_cnt_d;
        end
    end
`else
    // Without the output stage every held word lives in RAM and the head is read directly.
    assign ram_rd      = pop;
    assign st_cnt      = count_q;
    assign bus.val_out = (count_q != CNT_WIDTH'(0));
    assign bus.dout    = mem_q[rptr_q];
`endif

    // Pointer and total-occupancy next state.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (ram_rd) begin
            rptr_d = rptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_WIDTH'(1);
            2'b01:   count_d = count_q - CNT_WIDTH'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; reset discards contents without waiting for a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage write on accepted upstream words.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= bus.din;
        end
    end
endmodule

// File: doc/stream_fifo_link.md
# stream_fifo_link

Elastic 32-bit valid/ready buffer placed between two RISC-V stream tiles. It takes the upstream tile's `val_out`/`dout` stream into its input port and presents a decoupled stream to the downstream tile's `val_in`/`din` port. It absorbs bursts and breaks the combinational ready path between tiles, so each tile's handshake is timing-closed independently.

## Interface
- `DATA_WIDTH`, 32, payload width in bits.
- `DEPTH`, 16, storage entries; must be a power of two and at least 2.
- `CNT_WIDTH`, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `val_in`  in  1  upstream data valid.
- `ready_upward`  out  1  buffer can accept a word this cycle.
- `din`  in  DATA_WIDTH  upstream payload.
- `val_out`  out  1  downstream data valid.
- `ready_downward`  in  1  downstream accepts the word this cycle.
- `dout`  out  DATA_WIDTH  downstream payload.
- `count`  out  CNT_WIDTH  words held, including the output register when it is present.

## Operation
- Push occurs when `val_in && ready_upward`. Pop occurs when `val_out && ready_downward`.
- Storage is a circular RAM with write pointer `wptr` and read pointer `rptr`, each $clog2(DEPTH) bits. Pointers wrap naturally from DEPTH-1 to 0.
- `count` is a register:
  - +1 on a push alone.
  - −1 on a pop alone.
  - Unchanged on a simultaneous push and pop.
- Full and empty are derived from the storage occupancy, not from pointer equality.
- `ready_upward` = storage not full AND `reset` deasserted. It never depends combinationally on `ready_downward`.
  - When full, a push is refused even if a pop happens in the same cycle. `ready_upward` rises in the cycle after the pop.
- The buffer is first-word-fall-through. `dout` holds the oldest word whenever `val_out` = 1.
- `dout` and `val_out` stay stable while `val_out && !ready_downward`; the upstream side is not affected by that stall.
- Empty with `val_in` = 1: the word is written and no pop occurs that cycle, because `val_out` = 0. There is no same-cycle bypass.
- Order is preserved. There is no drop path and no overflow or underflow under legal handshakes.
- Changes to `val_in`/`din` while `ready_upward` = 0 are ignored.

## Timing
- Reset, asynchronous: `wptr`, `rptr` and `count` = 0, `val_out` = 0, `ready_upward` = 0. `dout` is don't-care while `val_out` = 0.
- `ready_upward` = 1 in the first cycle after `reset` falls.
- Reset mid-transfer discards all contents immediately. A handshake in the reset cycle does not count.
- Latency, push to `val_out` = 1: 1 cycle without the output register, 2 cycles with it.
- Throughput: 1 word per cycle sustained when `ready_downward` is held at 1.
- Capacity: DEPTH words; DEPTH+1 with the output register.
- At full: `count` = DEPTH (or DEPTH+1 with the output register) and `ready_upward` = 0.

## Configuration
- Macro: `STREAM_FIFO_OUTREG_EN`.
- Defined:
  - `dout`/`val_out` come from a dedicated output register stage, which is loaded from RAM when it is empty or is being popped.
  - No combinational path exists from RAM to the outputs.
  - Latency is 2 cycles, capacity is DEPTH+1, and `count` includes the register.
- Undefined:
  - `dout` is read from RAM at `rptr`.
  - `val_out` = (`count` != 0).
  - Latency is 1 cycle and capacity is DEPTH.

## Test plan
- Reset, then push 0x00000001..0x00000005 with `ready_downward` = 1:
  - Output order is 1..5.
  - The first `val_out` appears 1 cycle after the first push (2 cycles with the macro).
  - `count` returns to 0.
- `ready_downward` = 0; push until `ready_upward` = 0:
  - Exactly 16 accepts (17 with the macro).
  - `count` = 16 (17).
  - A further `val_in` with 0xDEADBEEF is not stored.
- Full, with `val_in` = 1 and `ready_downward` = 1 for one cycle:
  - Pop only; `count` drops by 1.
  - `ready_upward` = 1 in the next cycle.
- Steady state at `count` = 3 with continuous push and pop of 40 words (0x100+i):
  - `count` stays 3.
  - Pointers wrap past 15 with no loss.
  - Output sequence is exact.
- Stall while `val_out` = 1 for 5 cycles:
  - `dout` stays constant.
  - Upstream pushes continue until full.
- Assert `reset` asynchronously, mid-cycle, with 7 words held:
  - `val_out`, `count` and `ready_upward` go to 0 without a clock edge.
  - After release, a push of 0xA5A5A5A5 is the first word out.
